neuron_act_quant: RTL and testbench
===================================

// Module: neuron_act_quant
// PURPOSE
//   Post-neuron activation/requantisation stage. Consumes the 17-bit signed dot-product sum
//   produced by the neuron MAC, adds a bias, rounds/shifts, applies optional ReLU and saturates
//   to an 8-bit signed activation for the next layer. Results queue in a small output FIFO
//   with valid/ready handshake; clipping events are counted for calibration.
// PARAMETERS
//   IN_W        17  width of signed neuron sum (in_data)
//   BIAS_W      16  width of signed bias
//   OUT_W        8  width of signed output activation
//   SHIFT_W      4  width of right-shift amount
//   FIFO_DEPTH   4  output FIFO entries (power of 2, >=2)
// PORTS
//   clk          in   1        clock, rising edge
//   reset        in   1        asynchronous, active-high reset
//   in_valid     in   1        in_data/bias/shift/relu_en valid this cycle
//   in_ready     out  1        stage can accept an input this cycle
//   in_data      in   IN_W     signed neuron sum
//   bias         in   BIAS_W   signed bias, sampled with in_data
//   shift        in   SHIFT_W  unsigned right-shift amount, sampled with in_data
//   relu_en      in   1        1 = clamp negatives to 0, sampled with in_data
//   out_valid    out  1        FIFO head valid
//   out_ready    in   1        consumer accepts head this cycle
//   out_data     out  OUT_W    signed activation at FIFO head
//   sat_count    out  16       number of saturated results, sticky at 16'hFFFF
//   clear_stats  in   1        synchronous clear of sat_count
// BEHAVIOUR
//   - Reset: reset, asynchronous, active-high; clock clk. Reset flushes pipeline and FIFO:
//     out_valid=0, out_data=0, sat_count=0, in_ready=1 after release. Mid-operation reset drops all
//     in-flight data; no partial outputs after release.
//   - Input handshake: accept when in_valid && in_ready. in_ready = (fifo_count + s1_valid) < FIFO_DEPTH,
//     registered terms only; no combinational path from out_ready or in_valid to in_ready.
//     A same-cycle pop does not raise in_ready. Accepted inputs are never dropped.
//   - Stage 1 (registered at accept edge): s1_sum = sext(in_data) + sext(bias), IN_W+1 bits,
//     exact (no overflow); shift and relu_en captured alongside. s1_valid set, cleared if no accept.
//   - Stage 2 (combinational from S1, written into FIFO on next edge):
//     shift==0: r = s1_sum; shift>0: r = (s1_sum + 2^(shift-1)) >>> shift (arithmetic,
//     round half toward +inf), computed at IN_W+2 bits. Shifts >= IN_W+1 are legal (result 0 or -1).
//     relu_en && r<0 -> r=0 (not a saturation event).
//     Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat flag = value was clipped.
//   - Latency: accept in cycle N -> out_valid=1 with that result in cycle N+2 when FIFO empty.
//     Full throughput (1/cycle) while out_ready held high. Order strictly preserved.
//   - FIFO: circular, FIFO_DEPTH entries, read/write pointers wrap modulo depth; simultaneous push
//     and pop when full or empty is legal, count unchanged for push+pop. out_data shows head;
//     holds stable while out_valid && !out_ready. out_data=0 when empty.
//   - sat_count: +1 on each FIFO write with sat flag; saturates at 16'hFFFF (no wrap).
//     clear_stats wins over same-cycle increment (result 0).
// TESTING
//   1 in=100,bias=28,shift=0,relu=0 -> out_data=127 (0x7F) at N+2, sat_count=1.
//   2 in=1004,bias=0,shift=3,relu=0 -> out_data=126 (rounded 125.5 up); in=1000 -> 125, no sat.
//   3 in=-500,bias=0,shift=2: relu=0 -> -125 (0x83); relu=1 -> 0, sat_count unchanged.
//   4 in=-65536,bias=-32768,shift=0 -> -128 (0x80), sat_count+1; shift=15 -> -3 (0xFD), no sat.
//   5 out_ready=0, in_valid held with 6 values: exactly 4 accepted, in_ready=0; release
//     out_ready -> 4 then remaining 2 emerge in order, none lost or duplicated.
//   6 reset asserted with 3 in FIFO + 1 in S1 -> out_valid=0 immediately, sat_count=0; after
//     release in_ready=1 and next input emerges alone at N+2. Also force sat_count=16'hFFFF: stays.

Source files
------------

// File: rtl/neuron_act_quant_if.sv
// Handshake bundle for the activation stage: input operand channel and output activation channel.
// Latency: none, signal grouping only.
// Backpressure: valid/ready on both channels, with the ready signals owned by the receiving side.
interface neuron_act_quant_if #(
    parameter int IN_W    = 17,
    parameter int BIAS_W  = 16,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [IN_W-1:0]    in_data;
    logic signed [BIAS_W-1:0]  bias;
    logic        [SHIFT_W-1:0] shift;
    logic                      relu_en;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [OUT_W-1:0]   out_data;

    // Producer of operands and consumer of activations
    modport master (
        output in_valid, in_data, bias, shift, relu_en, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The activation stage itself
    modport slave (
        input  in_valid, in_data, bias, shift, relu_en, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/neuron_act_quant.sv
// Neuron requantisation: bias add, round-half-up shift, optional ReLU, saturate to OUT_W, output FIFO.
// Latency: accept in cycle N -> result at FIFO head (out_valid) in cycle N+2 when the FIFO is empty.
// Backpressure: in_ready comes from registered occupancy only (FIFO count + stage-1 entry < depth).
module neuron_act_quant #(
    parameter int IN_W       = 17,
    parameter int BIAS_W     = 16,
    parameter int OUT_W      = 8,
    parameter int SHIFT_W    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    neuron_act_quant_if.slave bus,
    output logic [15:0]       sat_count,
    input  logic              clear_stats
);
    // One extra bit over the wider operand makes the bias add exact;
    // one more bit leaves headroom for the rounding constant.
    localparam int SUM_W = ((IN_W > BIAS_W) ? IN_W : BIAS_W) + 1;
    localparam int RND_W = SUM_W + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam logic signed [RND_W-1:0] MAX_V = RND_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] MIN_V = -MAX_V - RND_W'(1);

    logic                      s1_valid;
    logic signed [SUM_W-1:0]   s1_sum;
    logic        [SHIFT_W-1:0] s1_shift;
    logic                      s1_relu;

    logic signed [RND_W-1:0]   ext;
    logic signed [RND_W-1:0]   half;
    logic signed [RND_W-1:0]   rounded;
    logic signed [RND_W-1:0]   act;
    logic        [OUT_W-1:0]   res;
    logic                      res_sat;

    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    fifo_count;

    logic accept;
    logic push;
    logic pop;

    // Stage 1 always drains into the FIFO next cycle, so counting it here guarantees room for it.
    assign bus.in_ready  = ({1'b0, fifo_count} + (CW + 1)'(s1_valid)) < (CW + 1)'(FIFO_DEPTH);
    assign accept        = bus.in_valid && bus.in_ready;
    assign push          = s1_valid;
    assign bus.out_valid = (fifo_count != '0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;

    // Stage 1: capture the exact bias-added sum with its shift and ReLU controls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_shift <= '0;
            s1_relu  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum   <= SUM_W'(bus.in_data) + SUM_W'(bus.bias);
                s1_shift <= bus.shift;
                s1_relu  <= bus.relu_en;
            end
        end
    end

    // Stage 2: round-half-up arithmetic shift, ReLU, then clip to the output range
    always_comb begin
        ext     = RND_W'(s1_sum);
        half    = '0;
        rounded = ext;
        if (s1_shift != '0) begin
            half    = RND_W'(1) <<< (s1_shift - SHIFT_W'(1));
            rounded = (ext + half) >>> s1_shift;
        end
        act     = (s1_relu && (rounded < 0)) ? '0 : rounded;
        res     = act[OUT_W-1:0];
        res_sat = 1'b0;
        if (act > MAX_V) begin
            res     = MAX_V[OUT_W-1:0];
            res_sat = 1'b1;
        end else if (act < MIN_V) begin
            res     = MIN_V[OUT_W-1:0];
            res_sat = 1'b1;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally because depth is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents are only visible through a valid head, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= res;
    end

    // Clip counter for calibration: sticky at all-ones, and a clear overrides a same-cycle clip
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_count <= '0;
        end else if (clear_stats) begin
            sat_count <= '0;
        end else if (push && res_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_neuron_act_quant.sv
// Self-checking bench for neuron_act_quant: directed corner cases plus randomized traffic against a reference model.
// Latency: checks the N+2 first-result timing and the single-entry occupancy that follows it.
// Backpressure: random out_ready stalls, full-FIFO hold of in_ready, and head stability while stalled.
module tb_neuron_act_quant;
    localparam int IN_W       = 17;
    localparam int BIAS_W     = 16;
    localparam int OUT_W      = 8;
    localparam int SHIFT_W    = 4;
    localparam int FIFO_DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        clear_stats;
    logic [15:0] sat_count;

    neuron_act_quant_if #(.IN_W(IN_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) bus ();

    neuron_act_quant #(
        .IN_W(IN_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .sat_count   (sat_count),
        .clear_stats (clear_stats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int model_sat = 0;
    bit done = 0;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic, rounding to nearest with ties toward +inf.
    function automatic int ref_act(input int x, input int b, input int sh, input bit relu, output bit sat);
        longint s, num, d, q;
        s = longint'(x) + longint'(b);
        if (sh == 0) begin
            q = s;
        end else begin
            d   = longint'(1) << sh;
            num = s + d / 2;
            q   = num / d;
            if ((num % d) != 0 && num < 0) q = q - 1;
        end
        if (relu && q < 0) q = 0;
        sat = 1'b0;
        if (q > 127) begin
            q = 127;
            sat = 1'b1;
        end else if (q < -128) begin
            q = -128;
            sat = 1'b1;
        end
        return int'(q);
    endfunction

    // Present one operand and hold it until the stage accepts it; returns at the negedge before the accepting edge.
    task automatic send(input int x, input int b, input int sh, input bit relu);
        int waitc;
        int r;
        bit s;
        waitc = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = IN_W'(x);
        bus.bias     = BIAS_W'(b);
        bus.shift    = SHIFT_W'(sh);
        bus.relu_en  = relu;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                r = ref_act(x, b, sh, relu, s);
                exp_q.push_back(r);
                if (s && model_sat < 65535) model_sat++;
                break;
            end
            waitc++;
            if (waitc > 200) begin
                chk("accept_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Single isolated transaction with out_ready high: nothing at N+1, result at N+2, empty again at N+3.
    task automatic directed(input string tag, input int x, input int b, input int sh, input bit relu,
                            input int expd, input int exp_sat);
        send(x, b, sh, relu);
        idle();
        @(negedge clk);
        chk({tag, "_n1_valid"}, bus.out_valid, 0);
        @(negedge clk);
        chk({tag, "_n2_valid"}, bus.out_valid, 1);
        chk({tag, "_n2_data"}, bus.out_data, expd);
        @(negedge clk);
        chk({tag, "_n3_valid"}, bus.out_valid, 0);
        chk({tag, "_sat_count"}, sat_count, exp_sat);
    endtask

    // Scoreboard: every popped head must match the model in order; a stalled head must not change.
    logic [OUT_W-1:0] hold_dat;
    bit               hold_vld = 0;
    always @(negedge clk) begin
        if (reset) begin
            hold_vld = 0;
        end else begin
            if (hold_vld && bus.out_valid) chk("head_stable", bus.out_data, $signed(hold_dat));
            if (!bus.out_valid) chk("empty_data_zero", bus.out_data, 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                else chk("out_data", bus.out_data, exp_q.pop_front());
                hold_vld = 0;
            end else if (bus.out_valid) begin
                hold_vld = 1;
                hold_dat = bus.out_data;
            end else begin
                hold_vld = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        clear_stats   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.bias      = '0;
        bus.shift     = '0;
        bus.relu_en   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_sat_count", sat_count, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;

        // Rounding, ReLU and saturation corners
        directed("t1_pos_sat",   100,    28,     0,  1'b0, 127,  1);
        directed("t2_round_up",  1004,   0,      3,  1'b0, 126,  1);
        directed("t2_exact",     1000,   0,      3,  1'b0, 125,  1);
        directed("t3_neg",       -500,   0,      2,  1'b0, -125, 1);
        directed("t3_relu",      -500,   0,      2,  1'b1, 0,    1);
        directed("t4_neg_sat",   -65536, -32768, 0,  1'b0, -128, 2);
        directed("t4_shift15",   -65536, -32768, 15, 1'b0, -3,   2);

        // Fill with the consumer stalled: four accepted, the fifth held off until the head pops
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(10 * (i + 1), 0, 0, 1'b0);
        fork
            send(50, 0, 0, 1'b0);
            begin
                repeat (8) @(negedge clk);
                chk("t5_in_ready_full", bus.in_ready, 0);
                chk("t5_accepted", exp_q.size(), 4);
                chk("t5_head", bus.out_data, 10);
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        send(60, 0, 0, 1'b0);
        idle();
        drain();

        // Reset with three entries queued and one in stage 1
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(i + 1, 0, 0, 1'b0);
        idle();
        chk("t6_pre_valid", bus.out_valid, 1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_rst_valid", bus.out_valid, 0);
        chk("t6_rst_sat", sat_count, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t6_in_ready", bus.in_ready, 1);
        chk("t6_no_leftover", bus.out_valid, 0);
        directed("t6_after", 5, 0, 0, 1'b0, 5, 0);

        // Counter sticks at all-ones
        force dut.sat_count = 16'hFFFE;
        #1;
        release dut.sat_count;
        directed("sticky_a", 100, 28, 0, 1'b0, 127, 65535);
        directed("sticky_b", 200, 0,  0, 1'b0, 127, 65535);

        // Clear alone, then clear coinciding with a clipped write
        @(posedge clk); #1;
        clear_stats = 1'b1;
        @(posedge clk); #1;
        clear_stats = 1'b0;
        @(negedge clk);
        chk("clear_plain", sat_count, 0);
        send(-1000, 0, 0, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        clear_stats  = 1'b1;
        @(posedge clk); #1;
        clear_stats = 1'b0;
        @(negedge clk);
        chk("clear_wins", sat_count, 0);
        drain();

        // Randomized traffic with random consumer stalls
        model_sat = 0;
        fork
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [IN_W-1:0]   rx;
                    logic [BIAS_W-1:0] rb;
                    int                x;
                    int                b;
                    rx = IN_W'($urandom);
                    rb = BIAS_W'($urandom);
                    x  = int'($signed(rx));
                    b  = int'($signed(rb));
                    if ($urandom_range(0, 2) == 0) begin
                        x = int'($urandom_range(0, 400)) - 200;
                        b = int'($urandom_range(0, 60)) - 30;
                    end
                    send(x, b, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 4) == 0) idle();
                end
                idle();
                done = 1;
            end
        join
        drain();
        chk("rand_sat_count", sat_count, model_sat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
